pattern_serializer: RTL

Upstream stage of the `patternMoore` sequence detector. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, MSB first, onto the detector's serial `in` input. Consecutive words stream back to back, with no gap cycles, through a one-word holding register. A wrapping word counter supports checking against the detector's match count.

---
 rtl/pattern_serializer.sv | 116 +++++++++++
 1 files changed

// File: rtl/pattern_serializer.sv
// pattern_serializer: accepts parallel words over a valid/ready handshake
// and shifts them out MSB first, one bit per clock. A single holding
// register lets consecutive words stream back to back with no gap cycles.
// A wrapping 16-bit counter records how many words were fully shifted.
module pattern_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic [15:0]      words_sent
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] w_hold_next;
    logic             r_hold_full;
    logic             w_hold_full_next;
    logic [15:0]      r_words_sent;
    logic [15:0]      w_words_sent_next;
    logic             w_accept;

    // Ready depends only on the holding flag, never on data_valid.
    assign data_ready = !r_hold_full;
    assign w_accept   = data_valid && !r_hold_full;

    // Moore outputs decoded from the current state and registers.
    assign ser_out    = (r_state == S_SHIFT) ? r_sh[WIDTH-1] : IDLE_BIT;
    assign ser_valid  = (r_state == S_SHIFT);
    assign busy       = (r_state == S_SHIFT) || r_hold_full;
    assign words_sent = r_words_sent;

    // Next-state logic: loading, shifting, hold management and word counting.
    always_comb begin
        w_state_next      = r_state;
        w_sh_next         = r_sh;
        w_cnt_next        = r_cnt;
        w_hold_next       = r_hold;
        w_hold_full_next  = r_hold_full;
        w_words_sent_next = r_words_sent;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_sh_next    = data_in;
                    w_cnt_next   = '0;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt != LAST_BIT) begin
                    w_sh_next  = r_sh << 1;
                    w_cnt_next = r_cnt + 1'b1;
                    if (w_accept) begin
                        w_hold_next      = data_in;
                        w_hold_full_next = 1'b1;
                    end
                end else begin
                    // Last bit of the current word leaves this cycle.
                    w_words_sent_next = r_words_sent + 16'd1;
                    if (r_hold_full) begin
                        w_sh_next        = r_hold;
                        w_hold_full_next = 1'b0;
                        w_cnt_next       = '0;
                    end else if (w_accept) begin
                        w_sh_next  = data_in;
                        w_cnt_next = '0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight or held word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_sh         <= '0;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_words_sent <= 16'd0;
        end else begin
            r_state      <= w_state_next;
            r_sh         <= w_sh_next;
            r_cnt        <= w_cnt_next;
            r_hold       <= w_hold_next;
            r_hold_full  <= w_hold_full_next;
            r_words_sent <= w_words_sent_next;
        end
    end

endmodule
